// File: rtl/nmt_thread_scheduler_if.sv
// Bundle between the near-memory thread scheduler and its environment:
// predictor pulse, thread flags, instruction store, rank command path and host hand-off.
interface nmt_thread_scheduler_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_W        = 8
);
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                   context_switch;
  logic [NUM_THREADS-1:0] thread_ready;
  logic [1:0]             instr_op;
  logic                   nmt_op_ready;
  logic                   nmt_op_done;
  logic                   host_done;

  logic                   nmt_op_valid;
  logic [1:0]             nmt_op;
  logic [PC_W-1:0]        nmt_pc;
  logic [TID_W-1:0]       nmt_tid;
  logic                   rank_release;
  logic [15:0]            switch_count;
  logic                   protocol_err;

  modport master (
    input  context_switch, thread_ready, instr_op, nmt_op_ready, nmt_op_done, host_done,
    output nmt_op_valid, nmt_op, nmt_pc, nmt_tid, rank_release, switch_count, protocol_err
  );

  modport slave (
    output context_switch, thread_ready, instr_op, nmt_op_ready, nmt_op_done, host_done,
    input  nmt_op_valid, nmt_op, nmt_pc, nmt_tid, rank_release, switch_count, protocol_err
  );
endinterface

// File: rtl/nmt_thread_scheduler.sv
// Near-memory thread scheduler: issues ops for the running thread, drains and saves
// its PC on a context switch, hands the rank to the host, then restores round-robin.
module nmt_thread_scheduler #(
  parameter int NUM_THREADS     = 4,
  parameter int PC_W            = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                   clk,
  input logic                   rst,
  nmt_thread_scheduler_if.master bus
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, RESTORE, RUN, DRAIN, SAVE, HOST
  } state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_table_q [NUM_THREADS];
  logic [PC_W-1:0]  pc_q;
  logic [TID_W-1:0] tid_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic [15:0]      count_q;
  logic             err_q;
  logic             release_q;

  logic             valid;
  logic             issue;
  logic             drain_done;
  logic             pick_found;
  logic [TID_W-1:0] pick_tid;
  logic [TID_W-1:0] cand;

  // Valid must fall in the same cycle as the switch pulse, so it stays combinational.
  assign valid = (state_q == RUN) && (out_q < OUT_W'(MAX_OUTSTANDING)) &&
                 bus.thread_ready[tid_q] && !bus.context_switch;
  assign issue = valid && bus.nmt_op_ready;

  assign drain_done = (out_q == '0) || ((out_q == OUT_W'(1)) && bus.nmt_op_done);

  // Offsets are scanned from farthest to nearest so the nearest ready thread wins;
  // offset NUM_THREADS truncates to zero, making the current thread the last resort.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pick_found = 1'b0;
    pick_tid   = tid_q;
    cand       = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = tid_q + k[TID_W-1:0];
      if (bus.thread_ready[cand]) begin
        pick_found = 1'b1;
        pick_tid   = cand;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (issue && !bus.nmt_op_done) begin
      out_d = out_q + OUT_W'(1);
    end else if (!issue && bus.nmt_op_done && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      // NOTE: the PC table is architecturally cleared on reset, so it is a reset register
      // array rather than a RAM.
      for (int i = 0; i < NUM_THREADS; i++) pc_table_q[i] <= '0;
      pc_q      <= '0;
      tid_q     <= '0;
      out_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      release_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      release_q <= 1'b0;
      if (bus.nmt_op_done && (out_q == '0)) err_q <= 1'b1;
      if (issue) pc_q <= pc_q + PC_W'(1);

      case (state_q)
        IDLE:    if (|bus.thread_ready) state_q <= SELECT;
        SELECT: begin
          if (pick_found) begin
            tid_q   <= pick_tid;
            state_q <= RESTORE;
          end else begin
            state_q <= IDLE;
          end
        end
        RESTORE: begin
          pc_q    <= pc_table_q[tid_q];
          state_q <= RUN;
        end
        RUN: begin
          if (bus.context_switch) begin
            state_q <= DRAIN;
            if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
          end else if (!bus.thread_ready[tid_q]) begin
            state_q <= SAVE;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q   <= SAVE;
            release_q <= 1'b1;
          end
        end
        // release_q is only ever high in SAVE when the rank was drained for the host.
        SAVE: begin
          pc_table_q[tid_q] <= pc_q;
          state_q           <= release_q ? HOST : SELECT;
        end
        HOST:    if (bus.host_done) state_q <= SELECT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.nmt_op_valid = valid;
  assign bus.nmt_op       = valid ? bus.instr_op : 2'b00;
  assign bus.nmt_pc       = pc_q;
  assign bus.nmt_tid      = tid_q;
  assign bus.rank_release = release_q;
  assign bus.switch_count = count_q;
  assign bus.protocol_err = err_q;
endmodule
